// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y - borrowin, one bit per clock, LSB first,
// sequenced by a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             borrowin,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             borrowout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             b;

    logic             d;
    logic             b_next;
    logic [WIDTH-1:0] acc_next;

    // Full-subtractor cell on the operand LSBs; the difference bit enters at the
    // accumulator MSB so the result is fully assembled after WIDTH shifts.
    always_comb begin
        d        = xs[0] ^ ys[0] ^ b;
        b_next   = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
        acc_next = (acc >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            xs        <= '0;
            ys        <= '0;
            acc       <= '0;
            cnt       <= '0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            D         <= '0;
            borrowout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= X;
                        ys    <= Y;
                        b     <= borrowin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    b   <= b_next;
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        D         <= acc_next;
                        borrowout <= b_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
